// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microprogrammed fetch/execute control sequencer for the 8-bit bus CPU
//
// Purpose: steps through fetch (F0-F2), execute (E0-E3) and HALT states and
// decodes the current state plus opcode into the bus load/enable strobes.
//
// Ports:
//    clk      in   single clock, rising edge
//    clr      in   synchronous active-low reset
//    run      in   1 = advance one state per clock, 0 = freeze
//    opcode   in   [3:0] instruction register bits [7:4]
//    cp ep lm ce li ei la lb ev ea n eacc lo
//             out  PC inc, PC->bus, MAR load, RAM->bus, IR load, IR->bus,
//                  A load, B load, result load, result->bus, subtract,
//                  accumulator->bus, output load
//    hlt      out  machine halted
//    t_state  out  [2:0] current state code (debug)

module control_sequencer (
   input  logic       clk,
   input  logic       clr,
   input  logic       run,
   input  logic [3:0] opcode,
   output logic       cp,
   output logic       ep,
   output logic       lm,
   output logic       ce,
   output logic       li,
   output logic       ei,
   output logic       la,
   output logic       lb,
   output logic       ev,
   output logic       ea,
   output logic       n,
   output logic       eacc,
   output logic       lo,
   output logic       hlt,
   output logic [2:0] t_state
);

   localparam logic [2:0] S_F0   = 3'd0;
   localparam logic [2:0] S_F1   = 3'd1;
   localparam logic [2:0] S_F2   = 3'd2;
   localparam logic [2:0] S_E0   = 3'd3;
   localparam logic [2:0] S_E1   = 3'd4;
   localparam logic [2:0] S_E2   = 3'd5;
   localparam logic [2:0] S_E3   = 3'd6;
   localparam logic [2:0] S_HALT = 3'd7;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   logic [2:0] state_q, state_d;
   logic [3:0] op_q, op_d;
   logic       strobe_en;
   logic       op_q_arith;

   assign op_q_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

   // Next-state logic. HALT is left only through clr; run is ignored there.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      if (run && (state_q != S_HALT)) begin
         case (state_q)
            S_F0: state_d = S_F1;
            S_F1: state_d = S_F2;
            S_F2: state_d = S_E0;
            S_E0: begin
               // The live opcode is only trusted in E0; capture it for E1-E3.
               op_d = opcode;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: state_d = S_E1;
                  OP_HLT:                 state_d = S_HALT;
                  default:                state_d = S_F0;
               endcase
            end
            S_E1:    state_d = op_q_arith ? S_E2 : S_F0;
            S_E2:    state_d = S_E3;
            S_E3:    state_d = S_F0;
            default: state_d = S_F0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= S_F0;
         op_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Strobe decode. Gating with clr keeps the bus quiet during reset even
   // before the first edge has forced the state back to F0.
   assign strobe_en = run && clr;

   always_comb begin
      cp   = 1'b0;
      ep   = 1'b0;
      lm   = 1'b0;
      ce   = 1'b0;
      li   = 1'b0;
      ei   = 1'b0;
      la   = 1'b0;
      lb   = 1'b0;
      ev   = 1'b0;
      ea   = 1'b0;
      n    = 1'b0;
      eacc = 1'b0;
      lo   = 1'b0;
      if (strobe_en) begin
         case (state_q)
            S_F0: begin
               ep = 1'b1;
               lm = 1'b1;
            end
            S_F1: cp = 1'b1;
            S_F2: begin
               ce = 1'b1;
               li = 1'b1;
            end
            S_E0: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     ei = 1'b1;
                     lm = 1'b1;
                  end
                  OP_OUT: begin
                     eacc = 1'b1;
                     lo   = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_E1: begin
               if (op_q == OP_LDA) begin
                  ce = 1'b1;
                  la = 1'b1;
               end else if (op_q_arith) begin
                  ce = 1'b1;
                  lb = 1'b1;
               end
            end
            S_E2: begin
               ev = op_q_arith;
               n  = (op_q == OP_SUB);
            end
            S_E3: begin
               ea = op_q_arith;
               la = op_q_arith;
            end
            default: ;
         endcase
      end
   end

   assign hlt     = clr && (state_q == S_HALT);
   assign t_state = clr ? state_q : 3'd0;

endmodule
